// File: rtl/onehot_mux_arb.sv
// ----------------------------------------------------------------------------
// onehot_mux_arb
//
// Multi-channel valid/ready multiplexer with a one-slot registered output
// stage. Two grant modes:
//   io_mode = 0 : one-hot select. io_sel picks the channel. An io_sel that is
//                 not exactly one-hot while any input is valid raises a sticky
//                 error flag, and nothing is transferred that cycle.
//   io_mode = 1 : round-robin arbitration. The search starts at the channel
//                 after the last one granted and wraps around.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   io_in_data    CHANNELS*WIDTH flattened input data (channel k at [k*WIDTH +: WIDTH])
//   io_in_valid   per-channel valid
//   io_in_ready   per-channel ready (combinational, at most one bit high)
//   io_mode       0 = one-hot select, 1 = round-robin
//   io_sel        one-hot channel select (mode 0 only)
//   io_out_data   registered output data
//   io_out_valid  registered output valid
//   io_out_ready  downstream ready
//   io_out_chan   registered index of the channel that supplied io_out_data
//   io_err        sticky select-error flag
//   io_err_clr    synchronous clear of io_err (a same-cycle set wins)
// ----------------------------------------------------------------------------
module onehot_mux_arb #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int CW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] io_in_data,
  input  logic [CHANNELS-1:0]       io_in_valid,
  output logic [CHANNELS-1:0]       io_in_ready,
  input  logic                      io_mode,
  input  logic [CHANNELS-1:0]       io_sel,
  output logic [WIDTH-1:0]          io_out_data,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [CW-1:0]             io_out_chan,
  output logic                      io_err,
  input  logic                      io_err_clr
);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [CW-1:0]       r_out_chan;
  logic [CW-1:0]       r_ptr;
  logic                r_err;

  logic                w_load_en;
  logic                w_sel_ok;
  logic [CW-1:0]       w_sel_idx;
  logic                w_rr_found;
  logic [CW-1:0]       w_rr_idx;
  logic [CW-1:0]       w_grant_idx;
  logic [WIDTH-1:0]    w_grant_data;
  logic [CHANNELS-1:0] w_ready;
  logic                w_xfer;
  logic                w_err_set;

  // The output slot can take a new word when it is empty or being drained.
  assign w_load_en = !r_out_valid || io_out_ready;

  // One-hot select decode: count set bits and remember the (single) index.
  // NOTE: every signal driven in an always_comb gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin : p_sel_decode
    int v_cnt;
    v_cnt     = 0;
    w_sel_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (io_sel[k]) begin
        v_cnt     = v_cnt + 1;
        w_sel_idx = CW'(k);
      end
    end
    w_sel_ok = (v_cnt == 1);
  end

  // Round-robin search: walk offsets from CHANNELS down to 1 so that the
  // last hit, which wins, is the smallest offset after the pointer.
  always_comb begin : p_rr_search
    logic [CW-1:0] v_idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      v_idx = CW'((int'(r_ptr) + i) % CHANNELS);
      if (io_in_valid[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_idx;
      end
    end
  end

  // Ready generation. Held low throughout reset so nothing is accepted.
  always_comb begin : p_ready
    w_ready     = '0;
    w_grant_idx = io_mode ? w_rr_idx : w_sel_idx;
    if (reset && w_load_en) begin
      if (!io_mode) begin
        if (w_sel_ok) w_ready = io_sel;
      end else if (w_rr_found) begin
        w_ready[w_rr_idx] = 1'b1;
      end
    end
  end

  always_comb begin : p_data_mux
    w_grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_grant_idx == CW'(k)) w_grant_data = io_in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_xfer    = |(w_ready & io_in_valid);
  assign w_err_set = !io_mode && !w_sel_ok && (|io_in_valid);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_err       <= 1'b0;
      r_ptr       <= CW'(CHANNELS - 1);   // channel 0 gets first priority
    end else begin
      if (w_load_en) begin
        if (w_xfer) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_grant_data;
          r_out_chan  <= w_grant_idx;
          if (io_mode) r_ptr <= w_rr_idx;
        end else begin
          // Slot drained with nothing new: drop valid, keep data/chan.
          r_out_valid <= 1'b0;
        end
      end
      if (w_err_set)       r_err <= 1'b1;
      else if (io_err_clr) r_err <= 1'b0;
    end
  end

  assign io_in_ready  = w_ready;
  assign io_out_valid = r_out_valid;
  assign io_out_data  = r_out_data;
  assign io_out_chan  = r_out_chan;
  assign io_err       = r_err;

endmodule

// File: tb/tb_onehot_mux_arb.sv
// ----------------------------------------------------------------------------
// tb_onehot_mux_arb
//
// Directed bench for onehot_mux_arb (WIDTH=32, CHANNELS=4). A behavioural
// model of the output slot, error flag and round-robin pointer is compared
// with the DUT on every falling edge; directed scenarios add literal
// expectations worked out by hand.
// ----------------------------------------------------------------------------
module tb_onehot_mux_arb;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 2;

  logic            clock;
  logic            reset;
  logic [N*W-1:0]  io_in_data;
  logic [N-1:0]    io_in_valid;
  logic [N-1:0]    io_in_ready;
  logic            io_mode;
  logic [N-1:0]    io_sel;
  logic [W-1:0]    io_out_data;
  logic            io_out_valid;
  logic            io_out_ready;
  logic [CW-1:0]   io_out_chan;
  logic            io_err;
  logic            io_err_clr;

  int n_checks = 0;
  int n_errors = 0;

  onehot_mux_arb #(.WIDTH(W), .CHANNELS(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_data   (io_in_data),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_mode      (io_mode),
    .io_sel       (io_sel),
    .io_out_data  (io_out_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_chan  (io_out_chan),
    .io_err       (io_err),
    .io_err_clr   (io_err_clr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  logic         m_err;
  int           m_ptr;

  // Which input may be accepted right now, from the current inputs and state.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int idx;
    r = '0;
    if (!reset) return r;
    if (m_valid && !io_out_ready) return r;
    if (!io_mode) begin
      if ($countones(io_sel) == 1) r = io_sel;
    end else begin
      for (int i = 1; i <= N; i++) begin
        idx = (m_ptr + i) % N;
        if (io_in_valid[idx]) begin
          r[idx] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // Index of the channel transferring this cycle, or -1.
  function automatic int model_xfer();
    logic [N-1:0] r;
    r = model_ready();
    for (int k = 0; k < N; k++) if (r[k] && io_in_valid[k]) return k;
    return -1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= 0;
      m_err   <= 1'b0;
      m_ptr   <= N - 1;
    end else begin
      if (model_xfer() >= 0) begin
        m_valid <= 1'b1;
        m_chan  <= model_xfer();
        m_data  <= W'(io_in_data >> (model_xfer() * W));
        if (io_mode) m_ptr <= model_xfer();
      end else if (!m_valid || io_out_ready) begin
        m_valid <= 1'b0;
      end
      if (!io_mode && $countones(io_sel) != 1 && |io_in_valid) m_err <= 1'b1;
      else if (io_err_clr)                                     m_err <= 1'b0;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clock) begin
    check("cmp_in_ready",  64'(io_in_ready),  64'(model_ready()));
    check("cmp_out_valid", 64'(io_out_valid), 64'(m_valid));
    check("cmp_out_data",  64'(io_out_data),  64'(m_data));
    check("cmp_out_chan",  64'(io_out_chan),  64'(m_chan));
    check("cmp_err",       64'(io_err),       64'(m_err));
  end

  // -------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       mode;
    logic [3:0] sel;
    logic [3:0] valid;
    logic       oready;
  } vec_t;

  vec_t vecs[9];
  int   rr_exp[4];

  initial begin
    reset        = 1'b0;
    io_mode      = 1'b0;
    io_sel       = 4'b0001;
    io_in_valid  = 4'b1111;
    io_out_ready = 1'b1;
    io_err_clr   = 1'b0;
    for (int k = 0; k < N; k++) io_in_data[k*W +: W] = 32'hCAFE_0000 + 32'(k);

    // Reset state, with inputs requesting a transfer.
    #3;
    check("rst_out_valid", 64'(io_out_valid), 64'd0);
    check("rst_out_data",  64'(io_out_data),  64'd0);
    check("rst_out_chan",  64'(io_out_chan),  64'd0);
    check("rst_err",       64'(io_err),       64'd0);
    check("rst_in_ready",  64'(io_in_ready),  64'd0);

    // Release mid-cycle; the first rising edge afterwards transfers.
    @(negedge clock);
    #2;
    reset   = 1'b1;
    io_sel  = 4'b0100;
    #1;
    check("sel_ready", 64'(io_in_ready), 64'b0100);
    tick();
    check("sel_valid", 64'(io_out_valid), 64'd1);
    check("sel_data",  64'(io_out_data),  64'hCAFE_0002);
    check("sel_chan",  64'(io_out_chan),  64'd2);

    // Two-hot select with a valid input: error, no transfer.
    io_sel      = 4'b0110;
    io_in_valid = 4'b0010;
    #1;
    check("err_ready", 64'(io_in_ready), 64'd0);
    tick();
    check("err_valid", 64'(io_out_valid), 64'd0);
    check("err_flag",  64'(io_err),       64'd1);
    check("err_hold",  64'(io_out_data),  64'hCAFE_0002);
    io_sel      = 4'b0010;
    io_in_valid = 4'b0000;
    io_err_clr  = 1'b1;
    tick();
    check("err_clr", 64'(io_err), 64'd0);
    io_err_clr  = 1'b0;

    // Load a word and hold it, raise the error, then reset asynchronously.
    io_sel       = 4'b0001;
    io_in_valid  = 4'b0001;
    io_out_ready = 1'b0;
    tick();
    check("hold_valid", 64'(io_out_valid), 64'd1);
    check("hold_data",  64'(io_out_data),  64'hCAFE_0000);
    io_sel = 4'b0011;
    tick();
    check("hold_err",   64'(io_err),       64'd1);
    check("hold_valid2",64'(io_out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(io_out_valid), 64'd0);
    check("arst_data",  64'(io_out_data),  64'd0);
    check("arst_chan",  64'(io_out_chan),  64'd0);
    check("arst_err",   64'(io_err),       64'd0);
    check("arst_ready", 64'(io_in_ready),  64'd0);
    #2;
    reset        = 1'b1;
    io_mode      = 1'b1;
    io_in_valid  = 4'b1111;
    io_out_ready = 1'b1;

    // Round-robin over all four channels from reset: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_all_chan",  64'(io_out_chan),  64'(i % 4));
      check("rr_all_valid", 64'(io_out_valid), 64'd1);
    end

    // Sparse valids after a grant to ch3: 1,3,1,3.
    rr_exp = '{1, 3, 1, 3};
    io_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_sparse_chan", 64'(io_out_chan), 64'(rr_exp[i]));
    end

    // Output stall then full-throughput reload.
    io_mode     = 1'b0;
    io_sel      = 4'b0001;
    io_in_valid = 4'b0001;
    io_in_data[0 +: W] = 32'h1234_5678;
    tick();
    check("stall_load", 64'(io_out_data), 64'h1234_5678);
    io_out_ready = 1'b0;
    io_in_data[0 +: W] = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", 64'(io_in_ready), 64'd0);
      tick();
      check("stall_data",  64'(io_out_data),  64'h1234_5678);
      check("stall_chan",  64'(io_out_chan),  64'd0);
      check("stall_valid", 64'(io_out_valid), 64'd1);
    end
    io_out_ready = 1'b1;
    #1;
    check("unstall_ready", 64'(io_in_ready), 64'b0001);
    tick();
    check("unstall_valid", 64'(io_out_valid), 64'd1);
    check("unstall_data",  64'(io_out_data),  64'hAAAA_5555);

    // Set and clear of the error flag in the same cycle: set wins.
    io_sel     = 4'b0000;
    io_err_clr = 1'b1;
    tick();
    check("setwins_err", 64'(io_err), 64'd1);
    io_in_valid = 4'b0000;
    tick();
    check("clr_err", 64'(io_err), 64'd0);
    io_err_clr = 1'b0;

    // Mixed vectors, checked by the model only.
    vecs = '{
      '{1'b0, 4'b0001, 4'b0001, 1'b1},
      '{1'b0, 4'b0000, 4'b0000, 1'b1},
      '{1'b0, 4'b1000, 4'b0111, 1'b1},
      '{1'b1, 4'b1111, 4'b0100, 1'b0},
      '{1'b1, 4'b0000, 4'b0101, 1'b1},
      '{1'b1, 4'b0000, 4'b0001, 1'b1},
      '{1'b0, 4'b1001, 4'b0000, 1'b1},
      '{1'b1, 4'b0000, 4'b1111, 1'b0},
      '{1'b1, 4'b0000, 4'b1111, 1'b1}
    };
    foreach (vecs[i]) begin
      io_mode      = vecs[i].mode;
      io_sel       = vecs[i].sel;
      io_in_valid  = vecs[i].valid;
      io_out_ready = vecs[i].oready;
      tick();
    end

    io_in_valid = 4'b0000;
    repeat (3) tick();
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onehot_mux_arb.md
ONEHOT_MUX_ARB -- requirements
Module: onehot_mux_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel and of the output.
REQ-002 Parameter CHANNELS, default 4, number of input channels; legal range 2..16.
REQ-003 Derived CW = max(1, ceil(log2(CHANNELS))), the channel-index width.
REQ-004 clock  input  1  the single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 io_in_data  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 io_in_valid  input  CHANNELS  per-channel valid.
REQ-008 io_in_ready  output  CHANNELS  per-channel ready; combinational.
REQ-009 io_mode  input  1  0 = one-hot select mode, 1 = round-robin arbitration mode.
REQ-010 io_sel  input  CHANNELS  one-hot channel select; used only in mode 0.
REQ-011 io_out_data  output  WIDTH  registered output data.
REQ-012 io_out_valid  output  1  registered output valid.
REQ-013 io_out_ready  input  1  downstream ready.
REQ-014 io_out_chan  output  CW  registered index of the channel that supplied io_out_data.
REQ-015 io_err  output  1  sticky select-error flag.
REQ-016 io_err_clr  input  1  synchronous clear of io_err.

Function
REQ-017 Output stage is one register slot; load_en = !io_out_valid || io_out_ready.
REQ-018 Transfer on input k occurs in a cycle iff io_in_valid[k] && io_in_ready[k]; at most one io_in_ready bit is high per cycle.
REQ-019 Mode 0: sel_ok = io_sel has exactly one bit set; grant = io_sel when sel_ok, else 0.
REQ-020 Mode 0: io_in_ready[k] = load_en && sel_ok && io_sel[k]; valid on unselected channels is ignored.
REQ-021 Mode 0: io_err sets on any cycle where !sel_ok && (|io_in_valid); no transfer occurs that cycle.
REQ-022 Mode 1: grant is the first channel with io_in_valid set, searching from (ptr+1) mod CHANNELS upward with wrap-around; io_sel ignored, io_err never set.
REQ-023 Mode 1: io_in_ready[k] = load_en && grant[k]; ptr updates to the granted index only on a transfer.
REQ-024 On transfer: io_out_data <= granted channel data, io_out_chan <= granted index, io_out_valid <= 1, same edge; latency one cycle.
REQ-025 When load_en && no transfer: io_out_valid <= 0; data and chan hold their previous values.
REQ-026 When !load_en (valid held, ready low): io_out_data, io_out_chan, io_out_valid hold stable until accepted.
REQ-027 Simultaneous output accept and new transfer in one cycle: new word loads, io_out_valid stays 1, no bubble (full throughput).
REQ-028 io_err_clr clears io_err; if a set condition occurs in the same cycle, set wins.
REQ-029 io_mode changes take effect the next cycle's grant; ptr is retained across mode changes.

Reset
REQ-030 While reset low: io_out_valid=0, io_out_data=0, io_out_chan=0, io_err=0, ptr=CHANNELS-1 (channel 0 has first round-robin priority).
REQ-031 Reset asserted mid-transfer discards the held output word; no input is accepted while reset is low (io_in_ready=0).
REQ-032 After release, the first transfer is possible on the first rising edge with reset high.

Verification
REQ-033 Mode 0, io_sel=4'b0100, io_in_valid=4'b1111, ch2 data=32'hCAFE_0002, io_out_ready=1 -> next cycle io_out_valid=1, io_out_data=32'hCAFE_0002, io_out_chan=2, io_in_ready=4'b0100.
REQ-034 Mode 0, io_sel=4'b0110, io_in_valid=4'b0010 -> io_in_ready=0, no output, io_err=1 next cycle; pulse io_err_clr with io_sel=4'b0010 -> io_err=0.
REQ-035 Mode 1 after reset, all four valid, io_out_ready=1 for 8 cycles -> io_out_chan sequence 0,1,2,3,0,1,2,3, io_out_valid=1 every cycle.
REQ-036 Mode 1, io_in_valid=4'b1010, ptr after grant to ch3 -> grant order 1,3,1,3 (wrap-around skips idle channels).
REQ-037 Output stall: io_out_ready=0 for 3 cycles with word 32'h1234_5678 held -> io_out_data/chan stable, io_in_ready=0; ready rises -> next word loads same edge, no bubble.
REQ-038 Reset driven low while io_out_valid=1 -> io_out_valid=0, io_out_data=0, io_err=0 immediately (asynchronous); first post-reset mode-1 grant is ch0.
